dot_mac_sched: RTL and testbench



---
 rtl/dot_mac_sched.sv | 130 +++++++++++++
 tb/tb_dot_mac_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_mac_sched.sv
// Dot-product sequencer: one shared multiplier and one shared adder, one product per clock.
// Optional saturating arithmetic is enabled by defining DOT_SAT_EN.
module dot_mac_sched #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned IDX_W = 3
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           start,
  input  logic [N*W-1:0] w_flat,
  input  logic [N*W-1:0] x_flat,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   result,
  output logic           sat_flag
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DRAIN} state_t;

  state_t               state, state_nx;
  logic [N-1:0][W-1:0]  w_op, x_op;
  logic [IDX_W-1:0]     idx;
  logic [W-1:0]         acc, mult_q;
  logic                 mult_v;
  logic [W-1:0]         w_cur, x_cur, prod_w, add_res;
  logic                 last;

  assign last = (idx == IDX_W'(N - 1));
  assign busy = (state != S_IDLE);

  always_comb begin
    w_cur = '0;
    x_cur = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        w_cur = w_op[k];
        x_cur = x_op[k];
      end
    end
  end

  // The single adder serves both the running accumulate (MULT) and the final sum (DRAIN).
`ifdef DOT_SAT_EN
  logic [2*W-1:0] prod_full;
  logic [W:0]     add_full;
  logic           prod_clamp, add_clamp, sat_acc;

  always_comb begin
    prod_full  = {{W{1'b0}}, w_cur} * {{W{1'b0}}, x_cur};
    prod_clamp = |prod_full[2*W-1:W];
    prod_w     = prod_clamp ? '1 : prod_full[W-1:0];
    add_full   = {1'b0, acc} + {1'b0, mult_q};
    add_clamp  = add_full[W];
    add_res    = add_clamp ? '1 : add_full[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      sat_acc  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          sat_acc  <= 1'b0;
          sat_flag <= 1'b0;
        end
        S_MULT:  sat_acc  <= sat_acc | prod_clamp | (mult_v & add_clamp);
        S_DRAIN: sat_flag <= sat_acc | add_clamp;
        default: ;
      endcase
    end
  end
`else
  assign prod_w   = w_cur * x_cur;
  assign add_res  = acc + mult_q;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_MULT;
      S_MULT:  if (last)  state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      idx    <= '0;
      acc    <= '0;
      mult_q <= '0;
      mult_v <= 1'b0;
      result <= '0;
      done   <= 1'b0;
      w_op   <= '0;
      x_op   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          w_op   <= w_flat;
          x_op   <= x_flat;
          idx    <= '0;
          acc    <= '0;
          mult_v <= 1'b0;
        end
        S_MULT: begin
          mult_q <= prod_w;
          mult_v <= 1'b1;
          if (mult_v) acc <= add_res;
          if (!last)  idx <= idx + IDX_W'(1);
        end
        S_DRAIN: begin
          result <= add_res;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_mac_sched.sv
// Directed bench for dot_mac_sched (N=4, W=32) with a result scoreboard.
// Expected saturation behaviour follows DOT_SAT_EN when the bench is built with it.
module tb_dot_mac_sched;
  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rstb, start;
  logic [N*W-1:0] w_flat, x_flat;
  logic           busy, done, sat_flag;
  logic [W-1:0]   result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         sat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  dot_mac_sched #(.N(N), .W(W), .IDX_W(3)) dut (
    .clk(clk), .rstb(rstb), .start(start), .w_flat(w_flat), .x_flat(x_flat),
    .busy(busy), .done(done), .result(result), .sat_flag(sat_flag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic exp_t model(input logic [N*W-1:0] wf, input logic [N*W-1:0] xf);
    exp_t         e;
    logic [63:0]  p;
    logic [W:0]   s;
    e.res = '0;
    e.sat = 1'b0;
    for (int k = 0; k < N; k++) begin
      p = 64'(wf[k*W +: W]) * 64'(xf[k*W +: W]);
`ifdef DOT_SAT_EN
      if (p > 64'h0000_0000_FFFF_FFFF) begin
        p     = 64'h0000_0000_FFFF_FFFF;
        e.sat = 1'b1;
      end
`endif
      s = {1'b0, e.res} + {1'b0, p[W-1:0]};
`ifdef DOT_SAT_EN
      if (s[W]) begin
        s     = {1'b0, {W{1'b1}}};
        e.sat = 1'b1;
      end
`endif
      e.res = s[W-1:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rstb && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", result, e.res);
        check("sb_sat_flag", sat_flag, e.sat);
      end
    end
  end

  // Called at a falling edge; returns at the next falling edge (first cycle of the job).
  task automatic start_job(input logic [N*W-1:0] wf, input logic [N*W-1:0] xf);
    w_flat = wf;
    x_flat = xf;
    start  = 1'b1;
    exp_q.push_back(model(wf, xf));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    cyc    = 1;
    busy_n = 0;
    while (!done && cyc < 30) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cyc, bn, d_cnt, first, second;
    rstb   = 1'b0;
    start  = 1'b0;
    w_flat = '0;
    x_flat = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_sat", sat_flag, 0);
    rstb = 1'b1;
    @(negedge clk);

    // 1: single job, latency and busy window
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    wait_done(cyc, bn);
    check("t1_latency", cyc, 6);
    check("t1_busy_cycles", bn, 5);
    check("t1_busy_in_done", busy, 0);
    check("t1_result", result, 70);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_result_hold", result, 70);

    // 2: start held for 12 cycles -> back-to-back jobs
    start = 1'b1;
    exp_q.push_back(model(w_flat, x_flat));
    exp_q.push_back(model(w_flat, x_flat));
    d_cnt = 0; first = 0; second = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 12) start = 1'b0;
      if (done) begin
        d_cnt++;
        if (d_cnt == 1) first = c;
        else if (d_cnt == 2) second = c;
      end
    end
    check("t2_done_count", d_cnt, 2);
    check("t2_first_done", first, 6);
    check("t2_second_done", second, 12);

    // 3: start during a job with new operands is ignored
    start_job(pack4(2, 2, 2, 2), pack4(1, 2, 3, 4));
    @(negedge clk);
    w_flat = pack4(9, 9, 9, 9);
    x_flat = pack4(9, 9, 9, 9);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    d_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (done) d_cnt++;
      @(negedge clk);
    end
    check("t3_done_count", d_cnt, 1);
    check("t3_result", result, 20);
    check("t3_queue_empty", exp_q.size(), 0);

    // 4: reset at idx=2 aborts the job
    start_job(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    check("t4_busy", busy, 0);
    check("t4_result", result, 0);
    check("t4_done", done, 0);
    exp_q.delete();
    d_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) d_cnt++;
      @(negedge clk);
    end
    check("t4_no_done", d_cnt, 0);
    start_job(pack4(3, 3, 3, 3), pack4(4, 4, 4, 4));
    wait_done(cyc, bn);
    check("t4_new_result", result, 48);

    // 5: every product overflows W bits
    @(negedge clk);
    start_job(pack4(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000),
              pack4(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000));
    wait_done(cyc, bn);
`ifdef DOT_SAT_EN
    check("t5_result", result, 32'hFFFF_FFFF);
    check("t5_sat", sat_flag, 1);
`else
    check("t5_result", result, 0);
    check("t5_sat", sat_flag, 0);
`endif

    // 6: accumulator carry-out
    @(negedge clk);
    start_job(pack4(32'hFFFF_FFFF, 1, 0, 0), pack4(1, 1, 0, 0));
    wait_done(cyc, bn);
`ifdef DOT_SAT_EN
    check("t6_result", result, 32'hFFFF_FFFF);
    check("t6_sat", sat_flag, 1);
`else
    check("t6_result", result, 0);
    check("t6_sat", sat_flag, 0);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
